// File: rtl/dev_bus_pkg.sv
// Shared types and constants for the peripheral-bus arbiter.
// Optional build macro: DEV_BUS_ERR_EN (unmapped-address error reporting).
package dev_bus_pkg;

  // FSM state encoding
  typedef logic [1:0] state_t;
  localparam state_t IDLE   = 2'd0;
  localparam state_t ACCESS = 2'd1;
  localparam state_t DONE   = 2'd2;

  // Device windows, compared against address bits [31:4]
  localparam logic [27:0] DEV_TIMER_BASE = 28'h00007F0;
  localparam logic [27:0] DEV_OUT_BASE   = 28'h00007F1;
  localparam logic [27:0] DEV_IN_BASE    = 28'h00007F2;

  // Master index: 0 = CPU data port, 1 = DMA/debug port
  typedef logic mst_t;

  // True when the address falls in one of the three device windows
  function automatic logic addr_mapped(input logic [31:0] addr);
    return (addr[31:4] == DEV_TIMER_BASE) ||
           (addr[31:4] == DEV_OUT_BASE)   ||
           (addr[31:4] == DEV_IN_BASE);
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin pick. A lone request always wins;
// when both masters ask, the one named by prio wins.
module rr_arb2
  import dev_bus_pkg::*;
(
  input  logic [1:0] req,
  input  mst_t       prio,
  output logic       gnt_valid,
  output mst_t       gnt
);

  // Pick the winner from the request pair and the current priority
  always_comb begin
    gnt_valid = |req;
    if (req == 2'b11) gnt = prio;
    else              gnt = req[1];
  end

endmodule

// File: rtl/dev_bus_arbiter.sv
// Shares the peripheral-bus bridge port between the CPU data port (master 0)
// and the DMA/debug port (master 1). One fixed-length access at a time:
// IDLE (grant) -> ACCESS (WAIT_CYCLES+1 cycles) -> DONE (rdy pulse) -> IDLE.
// Optional build macro: DEV_BUS_ERR_EN adds bus_err and short-circuits
// accesses to unmapped addresses straight to DONE with zero read data.
//
// Handshake: a master raises mN_req with addr/we/wd stable and keeps it up
// until mN_rdy; mN_rdy is a single-cycle pulse and mN_rd is valid with it
// and held afterwards. The request must be low in the cycle after mN_rdy,
// otherwise it is treated as a fresh request. Request inputs are sampled
// only at the grant edge; later changes do not affect the running access.
module dev_bus_arbiter
  import dev_bus_pkg::*;
#(
  parameter int WAIT_CYCLES = 1,
  parameter int DW          = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          m0_req,
  input  logic [DW-1:0] m0_addr,
  input  logic          m0_we,
  input  logic [DW-1:0] m0_wd,
  output logic          m0_rdy,
  output logic [DW-1:0] m0_rd,
  input  logic          m1_req,
  input  logic [DW-1:0] m1_addr,
  input  logic          m1_we,
  input  logic [DW-1:0] m1_wd,
  output logic          m1_rdy,
  output logic [DW-1:0] m1_rd,
  output logic [DW-1:0] bus_addr,
  output logic [DW-1:0] bus_wd,
  output logic          bus_we,
  input  logic [DW-1:0] bus_rd,
  output logic          busy
`ifdef DEV_BUS_ERR_EN
  ,
  output logic          bus_err
`endif
);

  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES);

  state_t        state;
  mst_t          prio;
  mst_t          gnt;
  logic          we_lat;
  logic [3:0]    cnt;
  logic          arb_valid;
  mst_t          arb_gnt;
  logic [DW-1:0] sel_addr;
  logic [DW-1:0] sel_wd;
  logic          sel_we;
`ifdef DEV_BUS_ERR_EN
  logic          err_lat;
`endif

  rr_arb2 u_rr_arb2 (
    .req       ({m1_req, m0_req}),
    .prio      (prio),
    .gnt_valid (arb_valid),
    .gnt       (arb_gnt)
  );

  assign sel_addr = arb_gnt ? m1_addr : m0_addr;
  assign sel_wd   = arb_gnt ? m1_wd   : m0_wd;
  assign sel_we   = arb_gnt ? m1_we   : m0_we;

  // Sequencing: grant in IDLE, count down in ACCESS, rotate priority in DONE
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      prio     <= 1'b0;
      gnt      <= 1'b0;
      we_lat   <= 1'b0;
      cnt      <= 4'd0;
      bus_addr <= '0;
      bus_wd   <= '0;
      m0_rd    <= '0;
      m1_rd    <= '0;
`ifdef DEV_BUS_ERR_EN
      err_lat  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (arb_valid) begin
            gnt      <= arb_gnt;
            bus_addr <= sel_addr;
            bus_wd   <= sel_wd;
            we_lat   <= sel_we;
            cnt      <= CNT_INIT;
`ifdef DEV_BUS_ERR_EN
            if (!addr_mapped(32'(sel_addr))) begin
              // Unmapped: no device cycle, return zero data immediately
              err_lat <= 1'b1;
              state   <= DONE;
              if (arb_gnt) m1_rd <= '0;
              else         m0_rd <= '0;
            end else begin
              err_lat <= 1'b0;
              state   <= ACCESS;
            end
`else
            state    <= ACCESS;
`endif
          end
        end
        ACCESS: begin
          if (cnt == 4'd0) begin
            if (gnt) m1_rd <= bus_rd;
            else     m0_rd <= bus_rd;
            state <= DONE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        DONE: begin
          prio  <= ~gnt;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Write strobe only in the first ACCESS cycle (cnt still at its load value)
  assign bus_we = (state == ACCESS) && (cnt == CNT_INIT) && we_lat;
  assign m0_rdy = (state == DONE) && !gnt;
  assign m1_rdy = (state == DONE) && gnt;
  assign busy   = (state != IDLE);
`ifdef DEV_BUS_ERR_EN
  assign bus_err = (state == DONE) && err_lat;
`endif

endmodule

// File: tb/tb_dev_bus_arbiter.sv
// Directed bench for dev_bus_arbiter. Expected rdy events and bus write
// strobes are queued by the stimulus and consumed by a negedge monitor.
// Optional build macro: DEV_BUS_ERR_EN enables the unmapped-address tests.
module tb_dev_bus_arbiter;

  localparam int          W    = 1;
  localparam logic [31:0] MASK = 32'h5A5A_0000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT ----------------
  logic        m0_req, m0_we, m0_rdy, m1_req, m1_we, m1_rdy, bus_we, busy;
  logic [31:0] m0_addr, m0_wd, m0_rd, m1_addr, m1_wd, m1_rd;
  logic [31:0] bus_addr, bus_wd, bus_rd;
`ifdef DEV_BUS_ERR_EN
  logic        bus_err;
`endif

  // Bridge model: read data derived from the presented address unless overridden
  logic        ovr_en;
  logic [31:0] ovr_val;
  always_comb bus_rd = ovr_en ? ovr_val : (bus_addr ^ MASK);

  dev_bus_arbiter #(.WAIT_CYCLES(W), .DW(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .m0_req   (m0_req),
    .m0_addr  (m0_addr),
    .m0_we    (m0_we),
    .m0_wd    (m0_wd),
    .m0_rdy   (m0_rdy),
    .m0_rd    (m0_rd),
    .m1_req   (m1_req),
    .m1_addr  (m1_addr),
    .m1_we    (m1_we),
    .m1_wd    (m1_wd),
    .m1_rdy   (m1_rdy),
    .m1_rd    (m1_rd),
    .bus_addr (bus_addr),
    .bus_wd   (bus_wd),
    .bus_we   (bus_we),
    .bus_rd   (bus_rd),
    .busy     (busy)
`ifdef DEV_BUS_ERR_EN
    ,
    .bus_err  (bus_err)
`endif
  );

  // ---------------- scoreboard ----------------
  // exp_q entry: {err, master, cycle[15:0], rd[31:0]}
  logic [49:0] exp_q[$];
  // wr_q entry: {cycle[15:0], addr[31:0], wd[31:0]}
  logic [79:0] wr_q[$];
  int n_chk = 0;
  int n_err = 0;
  logic [31:0] exp_rd0, exp_rd1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%h expected 0x%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_rdy(input logic m, input logic [31:0] rd, input int c, input logic err);
    exp_q.push_back({err, m, 16'(c), rd});
  endtask

  function automatic logic mapped(input logic [31:0] a);
`ifdef DEV_BUS_ERR_EN
    return (a[31:4] == 28'h00007F0) || (a[31:4] == 28'h00007F1) || (a[31:4] == 28'h00007F2);
`else
    return 1'b1;
`endif
  endfunction

  // Monitor: consume an expectation whenever the DUT shows rdy or a write strobe
  always @(negedge clk) begin : monitor
    logic [49:0] e;
    logic [79:0] w;
    if (m0_rdy || m1_rdy) begin
      if (exp_q.size() == 0) chk("unexpected_rdy", 32'd1, 32'd0);
      else begin
        e = exp_q.pop_front();
        chk("rdy_both", {31'd0, m0_rdy && m1_rdy}, 32'd0);
        chk("rdy_master", {31'd0, m1_rdy}, {31'd0, e[48]});
        chk("rdy_cycle", {16'd0, cyc[15:0]}, {16'd0, e[47:32]});
        chk("rdy_rd", m1_rdy ? m1_rd : m0_rd, e[31:0]);
`ifdef DEV_BUS_ERR_EN
        chk("bus_err", {31'd0, bus_err}, {31'd0, e[49]});
`endif
      end
    end
`ifdef DEV_BUS_ERR_EN
    else if (bus_err) chk("err_without_rdy", 32'd1, 32'd0);
`endif
    if (bus_we) begin
      if (wr_q.size() == 0) chk("unexpected_bus_we", 32'd1, 32'd0);
      else begin
        w = wr_q.pop_front();
        chk("we_cycle", {16'd0, cyc[15:0]}, {16'd0, w[79:64]});
        chk("we_addr", bus_addr, w[63:32]);
        chk("we_wd", bus_wd, w[31:0]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero();
    chk("rst_bus_addr", bus_addr, 32'd0);
    chk("rst_bus_wd", bus_wd, 32'd0);
    chk("rst_bus_we", {31'd0, bus_we}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_m0_rdy", {31'd0, m0_rdy}, 32'd0);
    chk("rst_m1_rdy", {31'd0, m1_rdy}, 32'd0);
    chk("rst_m0_rd", m0_rd, 32'd0);
    chk("rst_m1_rd", m1_rd, 32'd0);
`ifdef DEV_BUS_ERR_EN
    chk("rst_bus_err", {31'd0, bus_err}, 32'd0);
`endif
  endtask

  // One isolated access by master m; request dropped the cycle after rdy
  task automatic do_single(input logic m, input logic [31:0] addr, input logic we,
                           input logic [31:0] wd);
    int t;
    logic [31:0] rd;
    logic ok;
    tick();
    t  = cyc;
    ok = mapped(addr);
    rd = ok ? (ovr_en ? ovr_val : (addr ^ MASK)) : 32'd0;
    if (!m) begin
      m0_req = 1'b1; m0_addr = addr; m0_we = we; m0_wd = wd;
    end else begin
      m1_req = 1'b1; m1_addr = addr; m1_we = we; m1_wd = wd;
    end
    if (ok) begin
      if (we) wr_q.push_back({16'(t + 1), addr, wd});
      push_rdy(m, rd, t + W + 2, 1'b0);
      repeat (W + 3) tick();
    end else begin
      push_rdy(m, 32'd0, t + 1, 1'b1);
      repeat (2) tick();
    end
    m0_req = 1'b0;
    m1_req = 1'b0;
    if (m) exp_rd1 = rd;
    else   exp_rd0 = rd;
  endtask

  // ---------------- stimulus ----------------
  initial begin : stim
    int t;
    m0_req = 0; m0_addr = 0; m0_we = 0; m0_wd = 0;
    m1_req = 0; m1_addr = 0; m1_we = 0; m1_wd = 0;
    ovr_en = 0; ovr_val = 0;
    exp_rd0 = 0; exp_rd1 = 0;

    // Reset state
    repeat (3) tick();
    @(negedge clk);
    check_all_zero();
    tick();
    reset = 1'b1;
    tick();

    // Master 0 write: strobe at T+1, rdy at T+3
    do_single(1'b0, 32'h0000_7F04, 1'b1, 32'h0000_1234);
    tick();

    // Reset in the middle of a master 1 write: no rdy, everything cleared
    tick();
    t = cyc;
    m1_req = 1'b1; m1_addr = 32'h0000_7F14; m1_we = 1'b1; m1_wd = 32'h0000_BEEF;
    wr_q.push_back({16'(t + 1), 32'h0000_7F14, 32'h0000_BEEF});
    tick();
    reset = 1'b0;
    m1_req = 1'b0;
    tick();
    @(negedge clk);
    check_all_zero();
    exp_rd0 = 0; exp_rd1 = 0;
    tick();
    reset = 1'b1;
    repeat (3) tick();

    // Both request after reset: prio back to 0, so master 0 then master 1
    tick();
    t = cyc;
    m0_req = 1'b1; m0_addr = 32'h0000_7F00; m0_we = 1'b0;
    m1_req = 1'b1; m1_addr = 32'h0000_7F10; m1_we = 1'b0;
    push_rdy(1'b0, 32'h0000_7F00 ^ MASK, t + W + 2, 1'b0);
    push_rdy(1'b1, 32'h0000_7F10 ^ MASK, t + 2 * W + 5, 1'b0);
    repeat (2 * W + 6) tick();
    m0_req = 1'b0; m1_req = 1'b0;
    exp_rd0 = 32'h0000_7F00 ^ MASK;
    exp_rd1 = 32'h0000_7F10 ^ MASK;

    // Master 1 read with fixed bridge data; master 0 read data untouched
    ovr_en = 1'b1; ovr_val = 32'hCAFE_0001;
    do_single(1'b1, 32'h0000_7F20, 1'b0, 32'd0);
    ovr_en = 1'b0;
    @(negedge clk);
    chk("m1_rd_hold", m1_rd, 32'hCAFE_0001);
    chk("m0_rd_untouched", m0_rd, exp_rd0);

    // Request dropped and address changed mid-ACCESS
    tick();
    t = cyc;
    m0_req = 1'b1; m0_addr = 32'h0000_7F08; m0_we = 1'b0;
    push_rdy(1'b0, 32'h0000_7F08 ^ MASK, t + W + 2, 1'b0);
    tick();
    m0_req = 1'b0; m0_addr = 32'h0000_7F2C;
    @(negedge clk);
    chk("drop_bus_addr_a", bus_addr, 32'h0000_7F08);
    chk("drop_busy", {31'd0, busy}, 32'd1);
    tick();
    @(negedge clk);
    chk("drop_bus_addr_b", bus_addr, 32'h0000_7F08);
    repeat (W + 1) tick();
    @(negedge clk);
    chk("idle_bus_addr_hold", bus_addr, 32'h0000_7F08);
    chk("idle_busy", {31'd0, busy}, 32'd0);
    exp_rd0 = 32'h0000_7F08 ^ MASK;

    // Both requests held continuously from reset: grants 0,1,0,1
    tick();
    reset = 1'b0;
    m0_req = 1'b1; m0_addr = 32'h0000_7F00; m0_we = 1'b0;
    m1_req = 1'b1; m1_addr = 32'h0000_7F24; m1_we = 1'b0;
    tick();
    reset = 1'b1;
    t = cyc;
    for (int k = 0; k < 4; k++)
      push_rdy(k[0], k[0] ? (32'h0000_7F24 ^ MASK) : (32'h0000_7F00 ^ MASK),
               t + (k + 1) * (W + 3) - 1, 1'b0);
    repeat (4 * (W + 3)) tick();
    m0_req = 1'b0; m1_req = 1'b0;
    tick();
    @(negedge clk);
    chk("rr_m0_rd", m0_rd, 32'h0000_7F00 ^ MASK);
    chk("rr_m1_rd", m1_rd, 32'h0000_7F24 ^ MASK);

`ifdef DEV_BUS_ERR_EN
    // Unmapped write, unmapped window just above the map, last mapped word
    do_single(1'b0, 32'h0000_1000, 1'b1, 32'h0000_DEAD);
    @(negedge clk);
    chk("err_m0_rd", m0_rd, 32'd0);
    do_single(1'b1, 32'h0000_7F30, 1'b0, 32'd0);
    do_single(1'b0, 32'h0000_7F2C, 1'b1, 32'h0000_0055);
`endif

    // Drain and final report
    repeat (4) tick();
    @(negedge clk);
    chk("rdy_q_empty", exp_q.size(), 32'd0);
    chk("wr_q_empty", wr_q.size(), 32'd0);
    chk("final_busy", {31'd0, busy}, 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  // Bound on total run time
  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "run did not finish");
  end

endmodule
